// File: rtl/battle_damage_unit.sv
// HP and move-power datapath for the battle FSM, with an 8-cycle shift-add damage multiplier.
// Define PBS_CRIT_EN to enable LFSR-driven critical hits (damage doubled after the shift).
module battle_damage_unit #(
  parameter int PLAYER_MAX_HP = 100,
  parameter int AI_MAX_HP     = 100,
  parameter int PLAYER_ATK    = 12,
  parameter int AI_ATK        = 10,
  parameter int DMG_SHIFT     = 3
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       ld_pm,
  input  logic       calc_ph,
  input  logic       apply_ad,
  input  logic       ld_am,
  input  logic       calc_ah,
  input  logic       apply_pd,
  input  logic [7:0] data_in,
  output logic       busy,
  output logic       done,
  output logic [7:0] damage,
  output logic [7:0] player_hp,
  output logic [7:0] ai_hp,
  output logic       hp_is_zero,
  output logic       crit
);
  localparam logic [7:0] P_MAX = 8'(PLAYER_MAX_HP);
  localparam logic [7:0] A_MAX = 8'(AI_MAX_HP);
  localparam logic [7:0] P_ATK = 8'(PLAYER_ATK);
  localparam logic [7:0] A_ATK = 8'(AI_ATK);

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;
  state_t state, state_nxt;

  logic [5:0]  strb, strb_prev, rise, act;
  logic        calc_go;
  logic [7:0]  pm, am, pwr, mplier;
  logic [15:0] mcand, acc, acc_nxt, prod_sh;
  logic [2:0]  cnt;
  logic [7:0]  dmg_sat, dmg_mul, dmg_final, ai_sub, pl_sub;

  // Bit order is the priority order: bit 0 (ld_pm) wins.
  assign strb = {apply_pd, calc_ah, ld_am, apply_ad, calc_ph, ld_pm};
  assign rise = strb & ~strb_prev;
  // Isolate the lowest set rising edge; edges outside IDLE are dropped, never queued.
  assign act     = (state == IDLE) ? (rise & (~rise + 6'd1)) : 6'd0;
  assign calc_go = act[1] | act[4];

  assign ai_sub = (ai_hp > damage) ? (ai_hp - damage) : 8'd0;
  assign pl_sub = (player_hp > damage) ? (player_hp - damage) : 8'd0;

  always_comb begin
    acc_nxt = acc + (mplier[0] ? mcand : 16'd0);
    prod_sh = acc_nxt >> DMG_SHIFT;
    dmg_sat = (|prod_sh[15:8]) ? 8'd255 : prod_sh[7:0];
    dmg_mul = dmg_sat;
`ifdef PBS_CRIT_EN
    if (crit) dmg_mul = dmg_sat[7] ? 8'd255 : {dmg_sat[6:0], 1'b0};
`endif
    // A nonzero move must always do at least one point of damage.
    dmg_final = ((dmg_mul == 8'd0) && (pwr != 8'd0)) ? 8'd1 : dmg_mul;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (calc_go) state_nxt = MUL;
      MUL:     if (cnt == 3'd7) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == MUL);
    done = (state == DONE);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      strb_prev  <= 6'd0;
      pm         <= 8'd0;
      am         <= 8'd0;
      pwr        <= 8'd0;
      mplier     <= 8'd0;
      mcand      <= 16'd0;
      acc        <= 16'd0;
      cnt        <= 3'd0;
      damage     <= 8'd0;
      player_hp  <= P_MAX;
      ai_hp      <= A_MAX;
      hp_is_zero <= 1'b0;
    end else begin
      strb_prev <= strb;
      if (act[0]) pm <= data_in;
      if (act[3]) am <= data_in;
      if (calc_go) begin
        pwr    <= act[1] ? pm : am;
        mplier <= act[1] ? pm : am;
        mcand  <= {8'd0, (act[1] ? P_ATK : A_ATK)};
        acc    <= 16'd0;
        cnt    <= 3'd0;
      end
      if (act[2]) begin
        ai_hp      <= ai_sub;
        hp_is_zero <= (ai_sub == 8'd0);
      end
      if (act[5]) begin
        player_hp  <= pl_sub;
        hp_is_zero <= (pl_sub == 8'd0);
      end
      if (state == MUL) begin
        acc    <= acc_nxt;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + 3'd1;
        if (cnt == 3'd7) damage <= dmg_final;
      end
    end
  end

`ifdef PBS_CRIT_EN
  logic [7:0] lfsr;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lfsr <= 8'hA5;
      crit <= 1'b0;
    end else begin
      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      if (calc_go) crit <= (lfsr[2:0] == 3'd0);
    end
  end
`else
  assign crit = 1'b0;
`endif
endmodule
